// File: rtl/processor_cu.sv
// Per-processor control unit: accepts a block index pair, reads operands A and B
// from shared memory, writes their product back. Define PCU_SATURATE_EN to clamp overflowing products.
module processor_cu #(
    parameter int PROC_ID         = 0,
    parameter int P               = 4,
    parameter int INDEX_WIDTH     = 8,
    parameter int MEMORY_SIZE_LOG = 10,
    parameter int A_BASE          = 2,
    parameter int B_OFFSET        = 256,
    parameter int R_OFFSET        = 512
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [P-1:0]               i_Indexes_Ready,
    input  logic [INDEX_WIDTH-1:0]     i_Row_Index,
    input  logic [INDEX_WIDTH-1:0]     i_Column_Index,
    input  logic [31:0]                i_Config,
    output logic                       o_Indexes_Received,
    output logic                       o_Grant_Request,
    input  logic                       i_Grant,
    output logic [MEMORY_SIZE_LOG-1:0] o_Memory_Address,
    inout  wire  [31:0]                io_Memory_Data,
    output logic                       o_Write_Enable,
    output logic                       o_Result_Ready
);

    localparam int MW = MEMORY_SIZE_LOG;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        REQ_GRANT,
        READ_A,
        READ_B,
        WRITE,
        DONE
    } state_t;

    state_t                 state_q;
    logic                   phase_q;
    logic [INDEX_WIDTH-1:0] rowIdx_q;
    logic [INDEX_WIDTH-1:0] colIdx_q;
    logic [31:0]            opA_q;
    logic [31:0]            result_q;
    logic [MW-1:0]          addr_q;
    logic                   busEn_q;
    logic                   dataEn_q;
    logic                   we_q;
    logic                   indexesReceived_q;
    logic                   grantReq_q;
    logic                   resultReady_q;

    logic                   ownReady;
    logic [7:0]             gamma;
    logic [MW-1:0]          offs_d;
    logic [MW-1:0]          aAddr_d;
    logic [MW-1:0]          bAddr_d;
    logic [MW-1:0]          rAddr_d;
    logic [63:0]            product_d;
    logic [31:0]            result_d;
    logic                   unusedBits;

    assign ownReady   = i_Indexes_Ready[PROC_ID];
    assign gamma      = i_Config[15:8];
    assign unusedBits = ^{i_Indexes_Ready, i_Config[31:16], i_Config[7:0]};

    // All address arithmetic wraps naturally in the memory address width.
    always_comb begin
        offs_d    = MW'(rowIdx_q) * MW'(gamma) + MW'(colIdx_q);
        aAddr_d   = MW'(A_BASE) + offs_d;
        bAddr_d   = aAddr_d + MW'(B_OFFSET);
        rAddr_d   = aAddr_d + MW'(R_OFFSET);
        product_d = {32'd0, opA_q} * {32'd0, io_Memory_Data};
`ifdef PCU_SATURATE_EN
        result_d  = (|product_d[63:32]) ? 32'hFFFF_FFFF : product_d[31:0];
`else
        result_d  = product_d[31:0];
`endif
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q           <= IDLE;
            phase_q           <= 1'b0;
            rowIdx_q          <= '0;
            colIdx_q          <= '0;
            opA_q             <= '0;
            result_q          <= '0;
            addr_q            <= '0;
            busEn_q           <= 1'b0;
            dataEn_q          <= 1'b0;
            we_q              <= 1'b0;
            indexesReceived_q <= 1'b0;
            grantReq_q        <= 1'b0;
            resultReady_q     <= 1'b0;
        end else begin
            indexesReceived_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (ownReady) begin
                        rowIdx_q          <= i_Row_Index;
                        colIdx_q          <= i_Column_Index;
                        resultReady_q     <= 1'b0;
                        indexesReceived_q <= 1'b1;
                        state_q           <= ACK;
                    end
                end
                ACK: begin
                    grantReq_q <= 1'b1;
                    state_q    <= REQ_GRANT;
                end
                REQ_GRANT: begin
                    if (i_Grant) begin
                        addr_q  <= aAddr_d;
                        busEn_q <= 1'b1;
                        we_q    <= 1'b0;
                        phase_q <= 1'b0;
                        state_q <= READ_A;
                    end
                end
                READ_A, READ_B, WRITE: begin
                    // Losing the grant abandons the whole access; it restarts from operand A.
                    if (!i_Grant) begin
                        busEn_q  <= 1'b0;
                        dataEn_q <= 1'b0;
                        we_q     <= 1'b0;
                        phase_q  <= 1'b0;
                        state_q  <= REQ_GRANT;
                    end else if (state_q == WRITE) begin
                        grantReq_q    <= 1'b0;
                        busEn_q       <= 1'b0;
                        dataEn_q      <= 1'b0;
                        we_q          <= 1'b0;
                        resultReady_q <= 1'b1;
                        state_q       <= DONE;
                    end else if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else if (state_q == READ_A) begin
                        opA_q   <= io_Memory_Data;
                        addr_q  <= bAddr_d;
                        phase_q <= 1'b0;
                        state_q <= READ_B;
                    end else begin
                        result_q <= result_d;
                        addr_q   <= rAddr_d;
                        dataEn_q <= 1'b1;
                        we_q     <= 1'b1;
                        phase_q  <= 1'b0;
                        state_q  <= WRITE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Indexes_Received = indexesReceived_q;
    assign o_Grant_Request    = grantReq_q;
    assign o_Result_Ready     = resultReady_q;
    assign o_Memory_Address   = busEn_q  ? addr_q   : {MW{1'bz}};
    assign o_Write_Enable     = busEn_q  ? we_q     : 1'bz;
    assign io_Memory_Data     = dataEn_q ? result_q : 32'bz;

endmodule

// File: tb/tb_processor_cu.sv
// Directed bench for processor_cu (PROC_ID=1) with a small shared-memory model
// that answers reads combinationally and captures writes on the clock edge.
module tb_processor_cu;

    localparam logic [31:0] expSat =
`ifdef PCU_SATURATE_EN
        32'hFFFF_FFFF;
`else
        32'h0000_0000;
`endif

    logic        i_Clock;
    logic        i_Reset;
    logic [3:0]  i_Indexes_Ready;
    logic [7:0]  i_Row_Index;
    logic [7:0]  i_Column_Index;
    logic [31:0] i_Config;
    logic        o_Indexes_Received;
    logic        o_Grant_Request;
    logic        i_Grant;
    logic [9:0]  o_Memory_Address;
    wire  [31:0] io_Memory_Data;
    logic        o_Write_Enable;
    logic        o_Result_Ready;

    logic [31:0] mem [0:1023];
    logic        tbLoad;
    logic [9:0]  tbAddr;
    logic [31:0] tbData;

    int testCount = 0;
    int failCount = 0;

    processor_cu #(.PROC_ID(1)) dut (
        .i_Clock            (i_Clock),
        .i_Reset            (i_Reset),
        .i_Indexes_Ready    (i_Indexes_Ready),
        .i_Row_Index        (i_Row_Index),
        .i_Column_Index     (i_Column_Index),
        .i_Config           (i_Config),
        .o_Indexes_Received (o_Indexes_Received),
        .o_Grant_Request    (o_Grant_Request),
        .i_Grant            (i_Grant),
        .o_Memory_Address   (o_Memory_Address),
        .io_Memory_Data     (io_Memory_Data),
        .o_Write_Enable     (o_Write_Enable),
        .o_Result_Ready     (o_Result_Ready)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    // Memory answers only while the unit owns the bus with write-enable low.
    assign io_Memory_Data = ((o_Write_Enable !== 1'bz) && !o_Write_Enable)
                            ? mem[o_Memory_Address] : 32'bz;

    always @(posedge i_Clock) begin
        if (tbLoad)
            mem[tbAddr] <= tbData;
        else if ((o_Write_Enable !== 1'bz) && o_Write_Enable)
            mem[o_Memory_Address] <= io_Memory_Data;
    end

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] ready, input logic [7:0] row, input logic [7:0] col);
        i_Indexes_Ready = ready;
        i_Row_Index     = row;
        i_Column_Index  = col;
    endtask

    task automatic loadWord(input logic [9:0] addr, input logic [31:0] data);
        tbLoad = 1'b1;
        tbAddr = addr;
        tbData = data;
        tick();
        tbLoad = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkFloat(input string tag, input logic isFloating);
        testCount++;
        assert (isFloating === 1'b1) else begin
            failCount++;
            $error("[TB] FAIL %s: observed driven expected high-Z", tag);
        end
    endtask

    initial begin
        i_Reset = 1'b1;
        i_Grant = 1'b1;
        i_Config = 32'h0000_0400;
        tbLoad = 1'b0;
        tbAddr = '0;
        tbData = '0;
        applyStimulus(4'b0000, 8'd0, 8'd0);

        // Asynchronous reset, checked before any clock edge.
        #2 i_Reset = 1'b0;
        #1;
        checkOutput("rst_ack", {31'd0, o_Indexes_Received}, 32'd0);
        checkOutput("rst_greq", {31'd0, o_Grant_Request}, 32'd0);
        checkOutput("rst_ready", {31'd0, o_Result_Ready}, 32'd0);
        checkFloat("rst_addr_z", o_Memory_Address === 10'bz);
        checkFloat("rst_we_z", o_Write_Enable === 1'bz);
        checkFloat("rst_data_z", io_Memory_Data === 32'bz);
        tick();
        tick();
        i_Reset = 1'b1;

        // Another processor's bit must not trigger this unit.
        applyStimulus(4'b0100, 8'd1, 8'd2);
        tick();
        checkOutput("foreign_ack1", {31'd0, o_Indexes_Received}, 32'd0);
        tick();
        checkOutput("foreign_ack2", {31'd0, o_Indexes_Received}, 32'd0);
        checkOutput("foreign_greq", {31'd0, o_Grant_Request}, 32'd0);
        applyStimulus(4'b0000, 8'd0, 8'd0);

        // Basic transaction: Gamma=4, row 1, col 2 -> offs 6, addrs 8/264/520.
        loadWord(10'd8, 32'd7);
        loadWord(10'd264, 32'd6);
        loadWord(10'd520, 32'd0);
        applyStimulus(4'b0010, 8'd1, 8'd2);
        tick();
        checkOutput("t1_ack", {31'd0, o_Indexes_Received}, 32'd1);
        checkOutput("t1_greq_ack", {31'd0, o_Grant_Request}, 32'd0);
        applyStimulus(4'b0000, 8'd0, 8'd0);
        tick();
        checkOutput("t1_ack_once", {31'd0, o_Indexes_Received}, 32'd0);
        checkOutput("t1_greq", {31'd0, o_Grant_Request}, 32'd1);
        checkFloat("t1_rg_addr_z", o_Memory_Address === 10'bz);
        tick();
        checkOutput("t1_addrA", {22'd0, o_Memory_Address}, 32'd8);
        checkOutput("t1_weA", {31'd0, o_Write_Enable}, 32'd0);
        applyStimulus(4'b0010, 8'd3, 8'd3);
        tick();
        checkOutput("t1_busy_ack", {31'd0, o_Indexes_Received}, 32'd0);
        checkOutput("t1_addrA2", {22'd0, o_Memory_Address}, 32'd8);
        applyStimulus(4'b0000, 8'd0, 8'd0);
        tick();
        checkOutput("t1_addrB", {22'd0, o_Memory_Address}, 32'd264);
        tick();
        tick();
        checkOutput("t1_addrR", {22'd0, o_Memory_Address}, 32'd520);
        checkOutput("t1_weW", {31'd0, o_Write_Enable}, 32'd1);
        checkOutput("t1_dataW", io_Memory_Data, 32'd42);
        checkOutput("t1_ready_pre", {31'd0, o_Result_Ready}, 32'd0);
        tick();
        checkOutput("t1_ready", {31'd0, o_Result_Ready}, 32'd1);
        checkOutput("t1_greq_done", {31'd0, o_Grant_Request}, 32'd0);
        checkFloat("t1_done_addr_z", o_Memory_Address === 10'bz);
        checkFloat("t1_done_we_z", o_Write_Enable === 1'bz);
        checkFloat("t1_done_data_z", io_Memory_Data === 32'bz);
        checkOutput("t1_mem520", mem[520], 32'd42);

        // Grant lost during READ_B for three cycles, then the access restarts.
        loadWord(10'd520, 32'd0);
        checkOutput("t2_ready_hold", {31'd0, o_Result_Ready}, 32'd1);
        applyStimulus(4'b0010, 8'd1, 8'd2);
        tick();
        checkOutput("t2_ack", {31'd0, o_Indexes_Received}, 32'd1);
        checkOutput("t2_ready_clr", {31'd0, o_Result_Ready}, 32'd0);
        applyStimulus(4'b0000, 8'd0, 8'd0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("t2_addrB", {22'd0, o_Memory_Address}, 32'd264);
        i_Grant = 1'b0;
        tick();
        checkFloat("t2_gap_addr_z", o_Memory_Address === 10'bz);
        checkFloat("t2_gap_data_z", io_Memory_Data === 32'bz);
        checkFloat("t2_gap_we_z", o_Write_Enable === 1'bz);
        checkOutput("t2_gap_greq", {31'd0, o_Grant_Request}, 32'd1);
        tick();
        checkFloat("t2_gap2_addr_z", o_Memory_Address === 10'bz);
        tick();
        checkFloat("t2_gap3_data_z", io_Memory_Data === 32'bz);
        i_Grant = 1'b1;
        tick();
        checkOutput("t2_reAddrA", {22'd0, o_Memory_Address}, 32'd8);
        tick();
        tick();
        checkOutput("t2_reAddrB", {22'd0, o_Memory_Address}, 32'd264);
        tick();
        tick();
        checkOutput("t2_dataW", io_Memory_Data, 32'd42);
        tick();
        checkOutput("t2_ready", {31'd0, o_Result_Ready}, 32'd1);
        checkOutput("t2_mem520", mem[520], 32'd42);

        // Gamma=0 uses the column alone; 2^16 * 2^16 overflows 32 bits.
        i_Config = 32'h0000_0000;
        loadWord(10'd5, 32'h0001_0000);
        loadWord(10'd261, 32'h0001_0000);
        loadWord(10'd517, 32'h1234_5678);
        applyStimulus(4'b0010, 8'd5, 8'd3);
        tick();
        applyStimulus(4'b0000, 8'd0, 8'd0);
        tick();
        tick();
        checkOutput("t3_addrA", {22'd0, o_Memory_Address}, 32'd5);
        tick();
        tick();
        checkOutput("t3_addrB", {22'd0, o_Memory_Address}, 32'd261);
        tick();
        tick();
        checkOutput("t3_addrR", {22'd0, o_Memory_Address}, 32'd517);
        checkOutput("t3_dataW", io_Memory_Data, expSat);
        tick();
        checkOutput("t3_mem517", mem[517], expSat);

        // Reset in the middle of WRITE: bus floats at once, nothing is written.
        i_Config = 32'h0000_0400;
        loadWord(10'd520, 32'h0000_BEEF);
        applyStimulus(4'b0010, 8'd1, 8'd2);
        tick();
        applyStimulus(4'b0000, 8'd0, 8'd0);
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        checkOutput("t4_weW", {31'd0, o_Write_Enable}, 32'd1);
        #2 i_Reset = 1'b0;
        #1;
        checkOutput("t4_rst_greq", {31'd0, o_Grant_Request}, 32'd0);
        checkFloat("t4_rst_addr_z", o_Memory_Address === 10'bz);
        checkFloat("t4_rst_data_z", io_Memory_Data === 32'bz);
        checkFloat("t4_rst_we_z", o_Write_Enable === 1'bz);
        checkOutput("t4_rst_ready", {31'd0, o_Result_Ready}, 32'd0);
        tick();
        i_Reset = 1'b1;
        tick();
        tick();
        checkOutput("t4_mem520", mem[520], 32'h0000_BEEF);
        checkOutput("t4_post_greq", {31'd0, o_Grant_Request}, 32'd0);
        checkOutput("t4_post_ready", {31'd0, o_Result_Ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
